// File: rtl/sd_scoreboard_arb.sv
// Round-robin request arbiter and txid-based response router in front of one scoreboard FSM.
// Define SD_SCOREBOARD_ARB_STATS_EN to build saturating per-requester grant counters.
module sd_scoreboard_arb #(
  parameter int width   = 8,
  parameter int items   = 64,
  parameter int inputs  = 4,
  parameter int txid_sz = 2,
  parameter int asz     = $clog2(items)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [inputs-1:0]       p_srdy,
  output logic [inputs-1:0]       p_drdy,
  input  logic [inputs-1:0]       p_req_type,
  input  logic [inputs*width-1:0] p_mask,
  input  logic [inputs*width-1:0] p_data,
  input  logic [inputs*asz-1:0]   p_itemid,
  output logic                    ip_srdy,
  input  logic                    ip_drdy,
  output logic                    ip_req_type,
  output logic [txid_sz-1:0]      ip_txid,
  output logic [width-1:0]        ip_mask,
  output logic [width-1:0]        ip_data,
  output logic [asz-1:0]          ip_itemid,
  input  logic                    ic_srdy,
  output logic                    ic_drdy,
  input  logic [txid_sz-1:0]      ic_txid,
  input  logic [width-1:0]        ic_data,
  output logic [inputs-1:0]       c_srdy,
  input  logic [inputs-1:0]       c_drdy,
  output logic [width-1:0]        c_data,
  output logic [inputs*16-1:0]    stat_grants
);

  if (txid_sz < $clog2(inputs)) begin : g_txid_chk
    $error("sd_scoreboard_arb: txid_sz is too narrow to carry a requester index");
  end
  if (inputs < 2 || inputs > 16) begin : g_inputs_chk
    $error("sd_scoreboard_arb: inputs must be in 2..16");
  end

  typedef enum logic {ARB_OPEN, ARB_LOCKED} arb_state_t;

  arb_state_t         state, state_nxt;
  logic [txid_sz-1:0] rr_ptr, rr_ptr_nxt;
  logic [txid_sz-1:0] lock_idx, lock_idx_nxt;
  logic [txid_sz-1:0] rr_sel, sel;
  logic               held_req, xfer, stall;

  // Winner is the requesting index at the smallest distance past rr_ptr.
  always_comb begin
    int best_d;
    int d;
    rr_sel = '0;
    best_d = inputs;
    d      = 0;
    for (int k = 0; k < inputs; k++) begin
      d = (k + inputs - 1 - int'(rr_ptr)) % inputs;
      if (p_srdy[k] && d < best_d) begin
        best_d = d;
        rr_sel = txid_sz'(k);
      end
    end
  end

  always_comb begin
    held_req = 1'b0;
    for (int k = 0; k < inputs; k++)
      if (lock_idx == txid_sz'(k)) held_req = p_srdy[k];
  end

  assign sel     = (state == ARB_LOCKED) ? lock_idx : rr_sel;
  assign ip_srdy = reset & ((state == ARB_LOCKED) ? held_req : |p_srdy);
  assign ip_txid = sel;
  assign xfer    = ip_srdy & ip_drdy;
  assign stall   = ip_srdy & ~ip_drdy;

  always_comb begin
    ip_req_type = 1'b0;
    ip_mask     = '0;
    ip_data     = '0;
    ip_itemid   = '0;
    p_drdy      = '0;
    for (int k = 0; k < inputs; k++) begin
      if (sel == txid_sz'(k)) begin
        ip_req_type = p_req_type[k];
        ip_mask     = p_mask[k*width +: width];
        ip_data     = p_data[k*width +: width];
        ip_itemid   = p_itemid[k*asz +: asz];
        p_drdy[k]   = xfer;
      end
    end
  end

  // A stalled request keeps ownership of the FSM port until it is accepted,
  // since masked writes occupy the FSM for two cycles.
  always_comb begin
    state_nxt    = state;
    rr_ptr_nxt   = rr_ptr;
    lock_idx_nxt = lock_idx;
    if (xfer) begin
      rr_ptr_nxt = sel;
      state_nxt  = ARB_OPEN;
    end else if (stall && state == ARB_OPEN) begin
      state_nxt    = ARB_LOCKED;
      lock_idx_nxt = sel;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= ARB_OPEN;
      rr_ptr   <= txid_sz'(inputs - 1);
      lock_idx <= '0;
    end else begin
      state    <= state_nxt;
      rr_ptr   <= rr_ptr_nxt;
      lock_idx <= lock_idx_nxt;
    end
  end

  // Responses whose txid names no requester are accepted and dropped.
  always_comb begin
    c_srdy  = '0;
    ic_drdy = reset;
    for (int k = 0; k < inputs; k++) begin
      if (ic_txid == txid_sz'(k)) begin
        c_srdy[k] = reset & ic_srdy;
        ic_drdy   = reset & c_drdy[k];
      end
    end
  end

  assign c_data = ic_data;

`ifdef SD_SCOREBOARD_ARB_STATS_EN
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  logic [15:0] grants [inputs];

  always_ff @(posedge clk) begin
    for (int k = 0; k < inputs; k++) begin
      if (!reset)         grants[k] <= '0;
      else if (p_drdy[k]) grants[k] <= sat_inc(grants[k]);
    end
  end

  always_comb begin
    stat_grants = '0;
    for (int k = 0; k < inputs; k++) stat_grants[k*16 +: 16] = grants[k];
  end
`else
  assign stat_grants = '0;
`endif

endmodule

// File: tb/tb_sd_scoreboard_arb.sv
// Bench for sd_scoreboard_arb: directed scenarios plus randomized traffic checked
// against a transaction-level round-robin model.
module tb_sd_scoreboard_arb;
  localparam int N = 4, W = 8, A = 6, T = 2;
  localparam int N3 = 3;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [N-1:0]   p_srdy, p_drdy, p_req_type, c_srdy, c_drdy;
  logic [N*W-1:0] p_mask, p_data;
  logic [N*A-1:0] p_itemid;
  logic           ip_srdy, ip_drdy, ip_req_type, ic_srdy, ic_drdy;
  logic [T-1:0]   ip_txid, ic_txid;
  logic [W-1:0]   ip_mask, ip_data, ic_data, c_data;
  logic [A-1:0]   ip_itemid;
  logic [N*16-1:0] stat_grants;

  logic [N3-1:0]   p_srdy3, p_drdy3, p_req_type3, c_srdy3, c_drdy3;
  logic [N3*W-1:0] p_mask3, p_data3;
  logic [N3*A-1:0] p_itemid3;
  logic            ip_srdy3, ip_drdy3, ip_req_type3, ic_srdy3, ic_drdy3;
  logic [T-1:0]    ip_txid3, ic_txid3;
  logic [W-1:0]    ip_mask3, ip_data3, ic_data3, c_data3;
  logic [A-1:0]    ip_itemid3;
  logic [N3*16-1:0] stat_grants3;

  int n_cmp = 0;
  int n_fail = 0;
  int  m_last;
  bit  m_held;
  int  m_held_idx;

  sd_scoreboard_arb #(.width(W), .items(64), .inputs(N), .txid_sz(T)) dut (
    .clk(clk), .reset(reset),
    .p_srdy(p_srdy), .p_drdy(p_drdy), .p_req_type(p_req_type), .p_mask(p_mask),
    .p_data(p_data), .p_itemid(p_itemid),
    .ip_srdy(ip_srdy), .ip_drdy(ip_drdy), .ip_req_type(ip_req_type), .ip_txid(ip_txid),
    .ip_mask(ip_mask), .ip_data(ip_data), .ip_itemid(ip_itemid),
    .ic_srdy(ic_srdy), .ic_drdy(ic_drdy), .ic_txid(ic_txid), .ic_data(ic_data),
    .c_srdy(c_srdy), .c_drdy(c_drdy), .c_data(c_data), .stat_grants(stat_grants)
  );

  sd_scoreboard_arb #(.width(W), .items(64), .inputs(N3), .txid_sz(T)) dut3 (
    .clk(clk), .reset(reset),
    .p_srdy(p_srdy3), .p_drdy(p_drdy3), .p_req_type(p_req_type3), .p_mask(p_mask3),
    .p_data(p_data3), .p_itemid(p_itemid3),
    .ip_srdy(ip_srdy3), .ip_drdy(ip_drdy3), .ip_req_type(ip_req_type3), .ip_txid(ip_txid3),
    .ip_mask(ip_mask3), .ip_data(ip_data3), .ip_itemid(ip_itemid3),
    .ic_srdy(ic_srdy3), .ic_drdy(ic_drdy3), .ic_txid(ic_txid3), .ic_data(ic_data3),
    .c_srdy(c_srdy3), .c_drdy(c_drdy3), .c_data(c_data3), .stat_grants(stat_grants3)
  );

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    p_srdy = '0; p_req_type = '0; p_mask = '0; p_data = '0; p_itemid = '0;
    ip_drdy = 1'b0; ic_srdy = 1'b0; ic_txid = '0; ic_data = '0; c_drdy = '0;
    @(negedge clk);
    reset = 1'b1;
    m_last = N - 1; m_held = 1'b0; m_held_idx = 0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset = 1'b0; p_srdy = '1; ip_drdy = 1'b1; ic_srdy = 1'b1; ic_txid = 2'd1; c_drdy = '1;
    ic_srdy3 = 1'b1; ic_txid3 = 2'd3; c_drdy3 = '1; p_srdy3 = '1; ip_drdy3 = 1'b1;
    #1;
    n_cmp++; if (ip_srdy !== 1'b0) begin n_fail++; $display("FAIL reset_ip_srdy: got %b expected 0", ip_srdy); end
    n_cmp++; if (p_drdy !== 4'b0000) begin n_fail++; $display("FAIL reset_p_drdy: got %b expected 0000", p_drdy); end
    n_cmp++; if (c_srdy !== 4'b0000) begin n_fail++; $display("FAIL reset_c_srdy: got %b expected 0000", c_srdy); end
    n_cmp++; if (ic_drdy !== 1'b0) begin n_fail++; $display("FAIL reset_ic_drdy: got %b expected 0", ic_drdy); end
    n_cmp++; if (ic_drdy3 !== 1'b0) begin n_fail++; $display("FAIL reset_ic_drdy3: got %b expected 0", ic_drdy3); end
    n_cmp++; if (ip_srdy3 !== 1'b0) begin n_fail++; $display("FAIL reset_ip_srdy3: got %b expected 0", ip_srdy3); end
    p_srdy3 = '0; ip_drdy3 = 1'b0; ic_srdy3 = 1'b0;
  endtask

  task automatic test_round_robin();
    logic [T-1:0] exp_tx;
    do_reset();
    p_srdy = '1; p_req_type = '0; ip_drdy = 1'b1;
    p_data = {8'h33, 8'h22, 8'h11, 8'h00};
    for (int i = 0; i < 8; i++) begin
      exp_tx = T'(i % 4);
      #1;
      n_cmp++; if (ip_txid !== exp_tx) begin n_fail++; $display("FAIL rr_txid[%0d]: got %0d expected %0d", i, ip_txid, exp_tx); end
      n_cmp++; if (p_drdy !== (4'b0001 << exp_tx)) begin n_fail++; $display("FAIL rr_p_drdy[%0d]: got %b expected %b", i, p_drdy, 4'b0001 << exp_tx); end
      n_cmp++; if (ip_data !== 8'(17 * (i % 4))) begin n_fail++; $display("FAIL rr_data[%0d]: got %h expected %h", i, ip_data, 8'(17 * (i % 4))); end
      @(negedge clk);
    end
  endtask

  task automatic test_masked_write_hold();
    do_reset();
    p_data = {8'hD3, 8'h5A, 8'h11, 8'h00};
    p_mask = {8'hFF, 8'h0F, 8'h00, 8'h00};
    p_req_type = 4'b0100; p_srdy = 4'b1100; ip_drdy = 1'b0;
    #1;
    n_cmp++; if (ip_txid !== 2'd2) begin n_fail++; $display("FAIL hold_txid0: got %0d expected 2", ip_txid); end
    n_cmp++; if (ip_mask !== 8'h0F) begin n_fail++; $display("FAIL hold_mask0: got %h expected 0f", ip_mask); end
    n_cmp++; if (ip_req_type !== 1'b1) begin n_fail++; $display("FAIL hold_type0: got %b expected 1", ip_req_type); end
    n_cmp++; if (p_drdy !== 4'b0000) begin n_fail++; $display("FAIL hold_p_drdy0: got %b expected 0000", p_drdy); end
    @(negedge clk);
    p_srdy = 4'b1110; ip_drdy = 1'b1;
    #1;
    n_cmp++; if (ip_txid !== 2'd2) begin n_fail++; $display("FAIL hold_txid1: got %0d expected 2", ip_txid); end
    n_cmp++; if (ip_data !== 8'h5A) begin n_fail++; $display("FAIL hold_data1: got %h expected 5a", ip_data); end
    n_cmp++; if (p_drdy !== 4'b0100) begin n_fail++; $display("FAIL hold_p_drdy1: got %b expected 0100", p_drdy); end
    @(negedge clk);
    p_srdy = 4'b1010;
    #1;
    n_cmp++; if (ip_txid !== 2'd3) begin n_fail++; $display("FAIL hold_txid2: got %0d expected 3", ip_txid); end
    n_cmp++; if (ip_data !== 8'hD3) begin n_fail++; $display("FAIL hold_data2: got %h expected d3", ip_data); end
    n_cmp++; if (p_drdy !== 4'b1000) begin n_fail++; $display("FAIL hold_p_drdy2: got %b expected 1000", p_drdy); end
    @(negedge clk);
    p_srdy = '0;
  endtask

  task automatic test_response_routing();
    logic exp_rdy;
    ic_srdy = 1'b1; ic_txid = 2'd1; ic_data = 8'hA5; c_drdy = 4'b1101;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) c_drdy = 4'b1111;
      exp_rdy = (i == 3);
      #1;
      n_cmp++; if (c_srdy !== 4'b0010) begin n_fail++; $display("FAIL resp_c_srdy[%0d]: got %b expected 0010", i, c_srdy); end
      n_cmp++; if (c_data !== 8'hA5) begin n_fail++; $display("FAIL resp_c_data[%0d]: got %h expected a5", i, c_data); end
      n_cmp++; if (ic_drdy !== exp_rdy) begin n_fail++; $display("FAIL resp_ic_drdy[%0d]: got %b expected %b", i, ic_drdy, exp_rdy); end
      @(negedge clk);
    end
    ic_srdy = 1'b0;
  endtask

  task automatic test_out_of_range();
    ic_srdy3 = 1'b1; ic_txid3 = 2'd3; ic_data3 = 8'h3C; c_drdy3 = 3'b000;
    #1;
    n_cmp++; if (c_srdy3 !== 3'b000) begin n_fail++; $display("FAIL oor_c_srdy: got %b expected 000", c_srdy3); end
    n_cmp++; if (ic_drdy3 !== 1'b1) begin n_fail++; $display("FAIL oor_ic_drdy: got %b expected 1", ic_drdy3); end
    @(negedge clk);
    ic_txid3 = 2'd2; c_drdy3 = 3'b011;
    #1;
    n_cmp++; if (c_srdy3 !== 3'b100) begin n_fail++; $display("FAIL inr_c_srdy: got %b expected 100", c_srdy3); end
    n_cmp++; if (ic_drdy3 !== 1'b0) begin n_fail++; $display("FAIL inr_ic_drdy: got %b expected 0", ic_drdy3); end
    @(negedge clk);
    ic_srdy3 = 1'b0;
  endtask

  task automatic test_reset_mid_lock();
    do_reset();
    p_srdy = 4'b0010; ip_drdy = 1'b0;
    #1;
    n_cmp++; if (ip_txid !== 2'd1) begin n_fail++; $display("FAIL rml_lock_txid: got %0d expected 1", ip_txid); end
    @(negedge clk);
    reset = 1'b0; p_srdy = 4'b0011;
    #1;
    n_cmp++; if (ip_srdy !== 1'b0) begin n_fail++; $display("FAIL rml_ip_srdy: got %b expected 0", ip_srdy); end
    n_cmp++; if (p_drdy !== 4'b0000) begin n_fail++; $display("FAIL rml_p_drdy: got %b expected 0000", p_drdy); end
    @(negedge clk);
    reset = 1'b1; ip_drdy = 1'b1;
    #1;
    n_cmp++; if (ip_txid !== 2'd0) begin n_fail++; $display("FAIL rml_regrant_txid: got %0d expected 0", ip_txid); end
    n_cmp++; if (p_drdy !== 4'b0001) begin n_fail++; $display("FAIL rml_regrant_p_drdy: got %b expected 0001", p_drdy); end
    @(negedge clk);
    p_srdy = '0;
  endtask

  task automatic test_random();
    bit           rv [N];
    logic [W-1:0] rd [N];
    logic [W-1:0] rm [N];
    logic [A-1:0] ri [N];
    logic         rt [N];
    int           gcnt [N];
    int           exp_sel, idx;
    logic [N-1:0] exp_drdy, exp_csrdy;
    logic         exp_srdy, exp_icdrdy;
    do_reset();
    for (int k = 0; k < N; k++) begin
      rv[k] = 1'b0; rd[k] = '0; rm[k] = '0; ri[k] = '0; rt[k] = 1'b0; gcnt[k] = 0;
    end
    for (int cyc = 0; cyc < 400; cyc++) begin
      for (int k = 0; k < N; k++) begin
        if (!rv[k] && $urandom_range(0, 1) == 1) begin
          rv[k] = 1'b1; rd[k] = W'($urandom); rm[k] = W'($urandom);
          ri[k] = A'($urandom); rt[k] = 1'($urandom);
        end
        p_srdy[k] = rv[k]; p_req_type[k] = rt[k];
        p_data[k*W +: W] = rd[k]; p_mask[k*W +: W] = rm[k]; p_itemid[k*A +: A] = ri[k];
      end
      ip_drdy = ($urandom_range(0, 3) != 0);
      ic_srdy = 1'($urandom); ic_txid = T'($urandom); ic_data = W'($urandom); c_drdy = N'($urandom);
      exp_sel = -1;
      if (m_held) begin
        if (rv[m_held_idx]) exp_sel = m_held_idx;
      end else begin
        for (int d = 1; d <= N; d++) begin
          idx = (m_last + d) % N;
          if (exp_sel < 0 && rv[idx]) exp_sel = idx;
        end
      end
      exp_srdy = (exp_sel >= 0);
      exp_drdy = '0;
      if (exp_sel >= 0 && ip_drdy) exp_drdy[exp_sel] = 1'b1;
      exp_csrdy = '0;
      if (ic_srdy) exp_csrdy[ic_txid] = 1'b1;
      exp_icdrdy = c_drdy[ic_txid];
      #1;
      n_cmp++; if (ip_srdy !== exp_srdy) begin n_fail++; $display("FAIL rnd_ip_srdy[%0d]: got %b expected %b", cyc, ip_srdy, exp_srdy); end
      n_cmp++; if (p_drdy !== exp_drdy) begin n_fail++; $display("FAIL rnd_p_drdy[%0d]: got %b expected %b", cyc, p_drdy, exp_drdy); end
      n_cmp++; if (c_srdy !== exp_csrdy) begin n_fail++; $display("FAIL rnd_c_srdy[%0d]: got %b expected %b", cyc, c_srdy, exp_csrdy); end
      n_cmp++; if (ic_drdy !== exp_icdrdy) begin n_fail++; $display("FAIL rnd_ic_drdy[%0d]: got %b expected %b", cyc, ic_drdy, exp_icdrdy); end
      n_cmp++; if (c_data !== ic_data) begin n_fail++; $display("FAIL rnd_c_data[%0d]: got %h expected %h", cyc, c_data, ic_data); end
      if (exp_sel >= 0) begin
        n_cmp++; if (ip_txid !== T'(exp_sel)) begin n_fail++; $display("FAIL rnd_txid[%0d]: got %0d expected %0d", cyc, ip_txid, exp_sel); end
        n_cmp++; if (ip_data !== rd[exp_sel]) begin n_fail++; $display("FAIL rnd_data[%0d]: got %h expected %h", cyc, ip_data, rd[exp_sel]); end
        n_cmp++; if (ip_mask !== rm[exp_sel]) begin n_fail++; $display("FAIL rnd_mask[%0d]: got %h expected %h", cyc, ip_mask, rm[exp_sel]); end
        n_cmp++; if (ip_itemid !== ri[exp_sel]) begin n_fail++; $display("FAIL rnd_itemid[%0d]: got %h expected %h", cyc, ip_itemid, ri[exp_sel]); end
        n_cmp++; if (ip_req_type !== rt[exp_sel]) begin n_fail++; $display("FAIL rnd_type[%0d]: got %b expected %b", cyc, ip_req_type, rt[exp_sel]); end
      end
      if (exp_sel >= 0 && ip_drdy) begin
        m_last = exp_sel; m_held = 1'b0; rv[exp_sel] = 1'b0; gcnt[exp_sel]++;
      end else if (exp_sel >= 0) begin
        m_held = 1'b1; m_held_idx = exp_sel;
      end
      @(negedge clk);
    end
    ic_srdy = 1'b0; p_srdy = '0;
`ifdef SD_SCOREBOARD_ARB_STATS_EN
    for (int k = 0; k < N; k++) begin
      n_cmp++; if (stat_grants[k*16 +: 16] !== 16'(gcnt[k])) begin n_fail++; $display("FAIL rnd_stat[%0d]: got %0d expected %0d", k, stat_grants[k*16 +: 16], gcnt[k]); end
    end
`else
    n_cmp++; if (stat_grants !== '0) begin n_fail++; $display("FAIL rnd_stat_tied: got %h expected 0", stat_grants); end
`endif
  endtask

  task automatic test_stats();
    do_reset();
    p_srdy = 4'b0010; ip_drdy = 1'b1;
    repeat (5) @(negedge clk);
`ifdef SD_SCOREBOARD_ARB_STATS_EN
    n_cmp++; if (stat_grants[31:16] !== 16'd5) begin n_fail++; $display("FAIL stat_req1: got %0d expected 5", stat_grants[31:16]); end
    p_srdy = 4'b0001;
    repeat (70000) @(negedge clk);
    n_cmp++; if (stat_grants[15:0] !== 16'hFFFF) begin n_fail++; $display("FAIL stat_sat: got %h expected ffff", stat_grants[15:0]); end
    n_cmp++; if (stat_grants[31:16] !== 16'd5) begin n_fail++; $display("FAIL stat_req1_kept: got %0d expected 5", stat_grants[31:16]); end
    n_cmp++; if (stat_grants[63:32] !== 32'd0) begin n_fail++; $display("FAIL stat_others: got %h expected 0", stat_grants[63:32]); end
`else
    n_cmp++; if (stat_grants !== '0) begin n_fail++; $display("FAIL stat_tied: got %h expected 0", stat_grants); end
`endif
    p_srdy = '0;
  endtask

  initial begin
    reset = 1'b0;
    p_srdy = '0; p_req_type = '0; p_mask = '0; p_data = '0; p_itemid = '0;
    ip_drdy = 1'b0; ic_srdy = 1'b0; ic_txid = '0; ic_data = '0; c_drdy = '0;
    p_srdy3 = '0; p_req_type3 = '0; p_mask3 = '0; p_data3 = '0; p_itemid3 = '0;
    ip_drdy3 = 1'b0; ic_srdy3 = 1'b0; ic_txid3 = '0; ic_data3 = '0; c_drdy3 = '0;
    m_last = N - 1; m_held = 1'b0; m_held_idx = 0;
    test_reset();
    test_round_robin();
    test_masked_write_hold();
    test_response_routing();
    test_out_of_range();
    test_reset_mid_lock();
    test_random();
    test_stats();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/sd_scoreboard_arb.md
Name: sd_scoreboard_arb

Overview:
- Shares a single scoreboard FSM request/response interface among `inputs` requesters.
- Round-robin arbitration on the request side; the granted index is used as the txid.
- Read responses are routed back to the originating requester by txid.
- Sits between N client blocks and one scoreboard FSM instance, which runs with use_txid=1.

Parameters:
- width, 8, scoreboard record width in bits
- items, 64, number of scoreboard entries
- inputs, 4, number of requesters (2..16)
- txid_sz, 2, txid width; must be >= $clog2(inputs); elaboration error otherwise
- asz, $clog2(items), item address width

Ports:
- clk  input  1  clock
- reset  input  1  synchronous, active-low reset
- p_srdy  input  inputs  per-requester request valid
- p_drdy  output  inputs  per-requester request accept
- p_req_type  input  inputs  per-requester 0=read, 1=write
- p_mask  input  inputs*width  per-requester write masks, packed, requester 0 in LSBs
- p_data  input  inputs*width  per-requester write data, packed
- p_itemid  input  inputs*asz  per-requester item ids, packed
- ip_srdy  output  1  request valid to scoreboard FSM
- ip_drdy  input  1  request accept from FSM
- ip_req_type  output  1  muxed request type
- ip_txid  output  txid_sz  index of the granted requester
- ip_mask  output  width  muxed mask
- ip_data  output  width  muxed data
- ip_itemid  output  asz  muxed item id
- ic_srdy  input  1  read response valid from FSM
- ic_drdy  output  1  read response accept to FSM
- ic_txid  input  txid_sz  read response txid
- ic_data  input  width  read response data
- c_srdy  output  inputs  per-requester response valid
- c_drdy  input  inputs  per-requester response accept
- c_data  output  width  response data, shared by all requesters
- stat_grants  output  inputs*16  per-requester grant counters (see Optional Feature)

Behaviour:
- Registered state:
  - rr_ptr: index of the last completed grant. Reset value inputs-1, so requester 0 wins first.
  - lock: 1 bit, reset value 0.
  - lock_idx: index of the held requester, reset value 0.
- Arbitration when lock=0:
  - Search p_srdy starting at (rr_ptr+1) mod inputs, wrapping around; the first set bit is sel.
  - ip_srdy=1 iff any p_srdy is set.
- When lock=1: sel=lock_idx, and ip_srdy = p_srdy[lock_idx].
- Request muxing: ip_req_type, ip_mask, ip_data and ip_itemid come from slice sel. ip_txid=sel, zero-extended to txid_sz.
- Request accept: p_drdy[sel] = ip_drdy & ip_srdy. All other p_drdy bits are 0.
- Transfer: a cycle with ip_srdy & ip_drdy.
  - On a transfer: rr_ptr<=sel and lock<=0.
- Stall: a cycle with ip_srdy & !ip_drdy.
  - On a stall with lock=0: lock<=1 and lock_idx<=sel.
  - On a stall with lock=1: hold the lock.
  - Purpose: masked writes take 2 cycles in the FSM, and the request must stay stable until accepted.
- Requesters must hold p_srdy and their payload until p_drdy. If p_srdy[lock_idx] drops while locked (protocol violation): ip_srdy=0 and the lock is held. This is a bench assertion error.
- Response routing, purely combinational with no added latency:
  - c_srdy[ic_txid] = ic_srdy; all other c_srdy bits are 0.
  - c_data = ic_data.
  - ic_drdy = c_drdy[ic_txid].
  - If ic_txid >= inputs: ic_drdy=1 and no c_srdy is raised (the response is dropped).
- Concurrency: request and response paths are independent. Requester k may present a new request while its read response is pending.
- Latency: requester to FSM is 0 cycles (combinational mux). Total read latency = FSM latency.
- Reset low, checked at clk edge: rr_ptr=inputs-1, lock=0, lock_idx=0, counters=0.
  - While reset is low: ip_srdy=0, all p_drdy=0, all c_srdy=0, ic_drdy=0.
  - Reset during a lock abandons the held request. The requester re-arbitrates after reset.
- Single requester active continuously: it is granted on every transfer, with no idle cycle between back-to-back grants.

Optional Feature:
- Macro: SD_SCOREBOARD_ARB_STATS_EN.
- Defined:
  - stat_grants[16k+15:16k] counts transfers for requester k.
  - Counter width is 16 bits; it saturates at 16'hFFFF (no wrap).
  - All counters clear on reset.
- Undefined: stat_grants is tied to 0 and no counter flops are inferred.

Test Plan:
- Round-robin fairness: inputs=4, all p_srdy=1 (reads), ip_drdy=1 constant -> ip_txid sequence 0,1,2,3,0,1; each p_drdy pulses once per 4 cycles.
- Masked-write hold: requester 2 writes mask=8'h0F; the FSM stub holds ip_drdy=0 for 1 cycle, then 1; requester 3 requests meanwhile -> ip_txid stays 2 for both cycles, then 3 next; ip_data is unchanged during the hold.
- Response routing: ic_srdy=1, ic_txid=1, ic_data=8'hA5, c_drdy[1]=0 for 3 cycles then 1 -> c_srdy=4'b0010 for 4 cycles, c_data=8'hA5, ic_drdy low 3 cycles then high.
- Out-of-range txid: inputs=3, txid_sz=2, ic_txid=3, ic_srdy=1 -> c_srdy=0, ic_drdy=1.
- Reset mid-lock: lock on requester 1, then reset low 1 cycle -> outputs 0 during reset; the next grant goes to requester 0 if p_srdy=4'b0011.
- Stats (macro defined): requester 0 granted 70000 times -> stat_grants[15:0]=16'hFFFF; other counters unaffected.
